// File: rtl/elevator_request_conditioner.sv
// Conditions raw cabin/hall buttons and the stop switch for Elevator_Top:
// synchronize, debounce, and turn each accepted button press into one pulse.
module elevator_request_conditioner #(
  parameter int FLOORS_NUM      = 5,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FLOORS_NUM-1:0] btn_int_raw,
  input  logic [FLOORS_NUM-1:0] btn_ext_raw,
  input  logic                  stop_raw,
  output logic [FLOORS_NUM-1:0] req_int,
  output logic [FLOORS_NUM-1:0] req_ext,
  output logic                  stop
);

  localparam int BTN_CH  = 2 * FLOORS_NUM;
  localparam int CH      = BTN_CH + 1;
  localparam int STOP_CH = BTN_CH;
  localparam int CW      = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CH-1:0]                  raw;
  logic [CH-1:0]                  synced;
  logic [SYNC_STAGES-1:0][CH-1:0] sff;
  logic [CH-1:0]                  stable;
  logic [CH-1:0]                  stable_d;
  logic [CH-1:0][CW-1:0]          cnt;
  logic [CH-1:0][CW-1:0]          cnt_d;
  logic [BTN_CH-1:0]              rise;
  logic [BTN_CH-1:0]              req_q;

  assign raw    = {stop_raw, btn_ext_raw, btn_int_raw};
  assign synced = sff[SYNC_STAGES-1];

  // Stop asserts on the first synced high; only its release is debounced.
  always_comb begin
    stable_d = stable;
    cnt_d    = '0;
    for (int ch = 0; ch < CH; ch++) begin
      if (ch == STOP_CH && synced[ch]) begin
        stable_d[ch] = 1'b1;
      end else if (synced[ch] != stable[ch]) begin
        if (cnt[ch] == CNT_LAST) begin
          stable_d[ch] = synced[ch];
        end else begin
          cnt_d[ch] = cnt[ch] + CW'(1);
        end
      end
    end
  end

  assign rise = stable_d[BTN_CH-1:0] & ~stable[BTN_CH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sff    <= '0;
      stable <= '0;
      cnt    <= '0;
      req_q  <= '0;
    end else begin
      sff[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sff[i] <= sff[i-1];
      end
      stable <= stable_d;
      cnt    <= cnt_d;
      req_q  <= rise;
    end
  end

  assign req_int = req_q[FLOORS_NUM-1:0];
  assign req_ext = req_q[BTN_CH-1:FLOORS_NUM];
  assign stop    = stable[STOP_CH];

endmodule

// File: tb/tb_elevator_request_conditioner.sv
// Directed bench for elevator_request_conditioner with SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, FLOORS_NUM=5.
module tb_elevator_request_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] btn_int_raw;
  logic [4:0] btn_ext_raw;
  logic       stop_raw;
  logic [4:0] req_int;
  logic [4:0] req_ext;
  logic       stop;

  int n_tests = 0;
  int n_fail  = 0;
  int pcount;
  int pfirst;
  logic [4:0] pint;
  logic [4:0] pext;

  elevator_request_conditioner #(
    .FLOORS_NUM     (5),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_int_raw(btn_int_raw),
    .btn_ext_raw(btn_ext_raw),
    .stop_raw   (stop_raw),
    .req_int    (req_int),
    .req_ext    (req_ext),
    .stop       (stop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic watch(input int n);
    pcount = 0;
    pfirst = -1;
    pint   = '0;
    pext   = '0;
    for (int k = 1; k <= n; k++) begin
      tick();
      if ((req_int | req_ext) != 5'b0) begin
        pcount++;
        if (pfirst < 0) begin
          pfirst = k;
          pint   = req_int;
          pext   = req_ext;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    btn_int_raw = '0;
    btn_ext_raw = '0;
    stop_raw    = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  int stop_in  [12] = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
  int stop_exp [12] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
  int b_pulses;

  initial begin
    rst_n       = 1'b1;
    btn_int_raw = '0;
    btn_ext_raw = '0;
    stop_raw    = 1'b0;

    // 1: async reset with all raw inputs high
    #1;
    rst_n       = 1'b0;
    btn_int_raw = '1;
    btn_ext_raw = '1;
    stop_raw    = 1'b1;
    #1;
    check("rst_req_int", 32'(req_int), 32'(0));
    check("rst_req_ext", 32'(req_ext), 32'(0));
    check("rst_stop",    32'(stop),    32'(0));
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_hold", 32'({req_int, req_ext, stop}), 32'(0));
    end
    btn_int_raw = '0;
    btn_ext_raw = '0;
    stop_raw    = 1'b0;
    rst_n       = 1'b1;
    watch(10);
    check("post_rst_pulses", 32'(pcount), 32'(0));
    check("post_rst_stop",   32'(stop),   32'(0));

    // 2: clean hall press on floor 2
    btn_ext_raw = 5'b00100;
    watch(20);
    check("clean_first", 32'(pfirst), 32'(6));
    check("clean_ext",   32'(pext),   32'(5'b00100));
    check("clean_int",   32'(pint),   32'(0));
    check("clean_count", 32'(pcount), 32'(1));
    btn_ext_raw = '0;
    watch(12);
    check("release_count", 32'(pcount), 32'(0));
    idle(4);

    // 3: bouncing cabin button 3
    b_pulses = 0;
    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p < 4; p++) begin
        btn_int_raw[3] = (p < 3);
        tick();
        if ((req_int | req_ext) != 5'b0) b_pulses++;
      end
    end
    check("bounce_pulses", 32'(b_pulses), 32'(0));
    btn_int_raw[3] = 1'b1;
    watch(12);
    check("bounce_first", 32'(pfirst), 32'(6));
    check("bounce_int",   32'(pint),   32'(5'b01000));
    check("bounce_count", 32'(pcount), 32'(1));
    idle(10);

    // 4: simultaneous presses
    btn_int_raw = 5'b10001;
    btn_ext_raw = 5'b00010;
    watch(12);
    check("simul_first", 32'(pfirst), 32'(6));
    check("simul_int",   32'(pint),   32'(5'b10001));
    check("simul_ext",   32'(pext),   32'(5'b00010));
    check("simul_count", 32'(pcount), 32'(1));
    idle(10);

    // 5: stop fast assert, bounced release
    for (int k = 0; k < 12; k++) begin
      stop_raw = stop_in[k][0];
      tick();
      check($sformatf("stop_e%0d", k + 1), 32'(stop), 32'(stop_exp[k]));
    end
    idle(10);

    // 6: reset mid-count, button held across reset
    stop_raw       = 1'b1;
    btn_ext_raw[0] = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    check("pre_rst_stop", 32'(stop),    32'(1));
    check("pre_rst_ext",  32'(req_ext), 32'(0));
    #2;
    rst_n    = 1'b0;
    stop_raw = 1'b0;
    #1;
    check("mid_rst_stop", 32'(stop),    32'(0));
    check("mid_rst_ext",  32'(req_ext), 32'(0));
    watch(3);
    check("in_rst_pulses", 32'(pcount), 32'(0));
    rst_n = 1'b1;
    watch(12);
    check("rst_rel_first", 32'(pfirst), 32'(6));
    check("rst_rel_ext",   32'(pext),   32'(5'b00001));
    check("rst_rel_count", 32'(pcount), 32'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
